// File: rtl/risc_8bit_pkg.sv
// Shared definitions for the 8-bit RISC demo core: opcodes, instruction
// field positions and the built-in default program.
package risc_8bit_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SHL  = 4'h6,
    OP_SHR  = 4'h7,
    OP_LDI  = 4'h8,
    OP_LD   = 4'h9,
    OP_ST   = 4'hA,
    OP_IN   = 4'hB,
    OP_OUT  = 4'hC,
    OP_JMP  = 4'hD,
    OP_BZ   = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  localparam int unsigned OP_HI  = 15;
  localparam int unsigned OP_LO  = 12;
  localparam int unsigned RD_HI  = 11;
  localparam int unsigned RD_LO  = 9;
  localparam int unsigned RS1_HI = 8;
  localparam int unsigned RS1_LO = 6;
  localparam int unsigned RS2_HI = 5;
  localparam int unsigned RS2_LO = 3;
  localparam int unsigned IMM_HI = 7;
  localparam int unsigned IMM_LO = 0;

  // Default program: IN r1; ADD r2,r1,r1; OUT r2; JMP 0
  localparam logic [15:0] PROG_IN_R1   = 16'hB200;
  localparam logic [15:0] PROG_ADD_R2  = 16'h1448;
  localparam logic [15:0] PROG_OUT_R2  = 16'hC080;
  localparam logic [15:0] PROG_JMP_0   = 16'hD000;
  localparam logic [15:0] PROG_HALT    = 16'hF000;

  function automatic logic [15:0] default_prog(input logic [7:0] addr);
    case (addr)
      8'd0:    return PROG_IN_R1;
      8'd1:    return PROG_ADD_R2;
      8'd2:    return PROG_OUT_R2;
      8'd3:    return PROG_JMP_0;
      default: return PROG_HALT;
    endcase
  endfunction

endpackage

// File: rtl/risc_8bit_if.sv
// Board I/O bundle: switches into the core, LEDs out of it.
interface risc_8bit_if;
  logic [7:0] sw;
  logic [7:0] led;

  modport master (output sw, input led);
  modport slave  (input sw, output led);
endinterface

// File: rtl/risc_8bit_alu.sv
// Combinational 8-bit ALU for opcodes ADD..SHR; carry/borrow is bit 8 of the
// 9-bit result, logic ops clear it.
module risc_8bit_alu
  import risc_8bit_pkg::*;
(
  input  opcode_e    op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y,
  output logic       z,
  output logic       c
);

  always_comb begin
    y = '0;
    c = 1'b0;
    case (op)
      OP_ADD:  {c, y} = {1'b0, a} + {1'b0, b};
      OP_SUB:  {c, y} = {1'b0, a} - {1'b0, b};
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SHL:  begin y = {a[6:0], 1'b0}; c = a[7]; end
      OP_SHR:  begin y = {1'b0, a[7:1]}; c = a[0]; end
      default: y = a;
    endcase
    z = (y == '0);
  end

endmodule

// File: rtl/risc_8bit.sv
// Single-cycle 8-bit RISC core: 256x16 ROM, 8x8 register file, 16x8 RAM,
// switch input through a 2-flop synchronizer, registered LED output.
module risc_8bit
  import risc_8bit_pkg::*;
#(
  parameter string PROG_FILE = ""
) (
  input  logic       clk,
  input  logic       rst_n,
  risc_8bit_if.slave io
);

  logic [15:0] rom [256];
  logic [7:0]  ram [16];
  logic [7:0]  regs [8];
  logic [7:0]  pc, led_q, sw_meta, sw_sync;
  logic        zf, cf, halted;

  logic [15:0] instr;
  opcode_e     op;
  logic [2:0]  rd, rs1, rs2;
  logic [7:0]  imm, a, b, rdv, alu_y, wr_data;
  logic        alu_z, alu_c, alu_op, wr_en;

  initial begin : rom_init
    for (int unsigned i = 0; i < 256; i++) rom[i] = default_prog(8'(i));
  end

  assign instr = rom[pc];
  assign op    = opcode_e'(instr[OP_HI:OP_LO]);
  assign rd    = instr[RD_HI:RD_LO];
  assign rs1   = instr[RS1_HI:RS1_LO];
  assign rs2   = instr[RS2_HI:RS2_LO];
  assign imm   = instr[IMM_HI:IMM_LO];

  // regs[0] is never written, so it reads as zero without a read-side mux
  assign a   = regs[rs1];
  assign b   = regs[rs2];
  assign rdv = regs[rd];

  assign alu_op = (op >= OP_ADD) && (op <= OP_SHR);

  risc_8bit_alu u_alu (
    .op (op),
    .a  (a),
    .b  (b),
    .y  (alu_y),
    .z  (alu_z),
    .c  (alu_c)
  );

  always_comb begin
    wr_en   = alu_op;
    wr_data = alu_y;
    case (op)
      OP_LDI:  begin wr_en = 1'b1; wr_data = imm;           end
      OP_LD:   begin wr_en = 1'b1; wr_data = ram[a[3:0]];   end
      OP_IN:   begin wr_en = 1'b1; wr_data = sw_sync;       end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= '0;
      zf      <= 1'b0;
      cf      <= 1'b0;
      led_q   <= '0;
      halted  <= 1'b0;
      sw_meta <= '0;
      sw_sync <= '0;
      for (int unsigned i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      sw_meta <= io.sw;
      sw_sync <= sw_meta;
      if (!halted) begin
        pc <= pc + 8'd1;
        if (wr_en && (rd != 3'd0)) regs[rd] <= wr_data;
        if (alu_op) begin
          zf <= alu_z;
          cf <= alu_c;
        end
        case (op)
          OP_OUT:  led_q <= a;
          OP_JMP:  pc <= imm;
          OP_BZ:   if (zf) pc <= imm;
          OP_HALT: begin pc <= pc; halted <= 1'b1; end
          default: ;
        endcase
      end
    end
  end

  // RAM keeps its contents across reset; a store is still blocked while reset is low
  always_ff @(posedge clk) begin
    if (rst_n && !halted && (op == OP_ST)) ram[a[3:0]] <= rdv;
  end

  assign io.led = led_q;

endmodule

// File: tb/tb_risc_8bit.sv
// Directed bench for risc_8bit: default program, per-instruction vector table
// and hand-written HALT / reset / pc-wrap sequences.
module tb_risc_8bit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  risc_8bit_if bus ();

  risc_8bit #(.PROG_FILE("")) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  always #5 clk = ~clk;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic [7:0][15:0] prog;
    logic [7:0]       led;
    logic             z;
    logic             c;
    logic [7:0]       pc;
  } vec_t;

  localparam int NV = 13;
  localparam logic [15:0] H = 16'hF000;
  vec_t vecs [NV];

  logic [7:0] dpc  [7] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3};
  logic [7:0] dled [7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h14};

  function automatic logic [15:0] rr(input logic [3:0] op, input logic [2:0] d,
                                     input logic [2:0] s1, input logic [2:0] s2);
    return {op, d, s1, s2, 3'b000};
  endfunction

  function automatic logic [15:0] ri(input logic [3:0] op, input logic [2:0] d,
                                     input logic [7:0] imm);
    return {op, d, 1'b0, imm};
  endfunction

  function automatic vec_t mk(input logic [15:0] p0, p1, p2, p3, p4, p5, p6, p7,
                              input logic [7:0] led, input logic z, input logic c,
                              input logic [7:0] pc);
    vec_t v;
    v.prog[0] = p0; v.prog[1] = p1; v.prog[2] = p2; v.prog[3] = p3;
    v.prog[4] = p4; v.prog[5] = p5; v.prog[6] = p6; v.prog[7] = p7;
    v.led = led; v.z = z; v.c = c; v.pc = pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fill_rom(input logic [15:0] w);
    for (int i = 0; i < 256; i++) dut.rom[i] = w;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin : main
    int   lat;
    logic seen;

    // LDI=8 ADD=1 SUB=2 AND=3 OR=4 XOR=5 SHL=6 SHR=7 LD=9 ST=A OUT=C JMP=D BZ=E
    vecs[0]  = mk(ri(8,1,8'h80), ri(8,2,8'h81), rr(1,3,1,2), rr(12,0,3,0), H, H, H, H, 8'h01, 0, 1, 8'd4);
    vecs[1]  = mk(ri(8,1,8'h05), ri(8,2,8'h07), rr(2,3,1,2), rr(12,0,3,0), H, H, H, H, 8'hFE, 0, 1, 8'd4);
    vecs[2]  = mk(ri(8,1,8'hF0), ri(8,2,8'h3C), rr(6,4,1,0), rr(3,3,1,2), rr(12,0,3,0), H, H, H, 8'h30, 0, 0, 8'd5);
    vecs[3]  = mk(ri(8,1,8'hF0), ri(8,2,8'h0F), rr(4,3,1,2), rr(12,0,3,0), H, H, H, H, 8'hFF, 0, 0, 8'd4);
    vecs[4]  = mk(ri(8,1,8'hAA), ri(8,2,8'h0F), rr(5,3,1,2), rr(12,0,3,0), H, H, H, H, 8'hA5, 0, 0, 8'd4);
    vecs[5]  = mk(ri(8,1,8'h81), rr(6,2,1,0), rr(12,0,2,0), H, H, H, H, H, 8'h02, 0, 1, 8'd3);
    vecs[6]  = mk(ri(8,1,8'h83), rr(7,2,1,0), rr(12,0,2,0), H, H, H, H, H, 8'h41, 0, 1, 8'd3);
    vecs[7]  = mk(ri(8,1,8'hA5), ri(8,2,8'h03), rr(10,1,2,0), rr(9,4,2,0), rr(12,0,4,0), H, H, H, 8'hA5, 0, 0, 8'd5);
    vecs[8]  = mk(ri(8,0,8'h55), ri(8,1,8'h80), rr(1,0,1,1), rr(12,0,0,0), H, H, H, H, 8'h00, 1, 1, 8'd4);
    vecs[9]  = mk(ri(8,1,8'h05), ri(8,2,8'h05), rr(2,3,1,2), ri(14,0,8'h06), rr(12,0,1,0), rr(12,0,3,0), H, H, 8'h00, 1, 0, 8'd6);
    vecs[10] = mk(ri(8,1,8'h05), ri(8,2,8'h04), rr(2,3,1,2), ri(14,0,8'h06), rr(12,0,1,0), rr(12,0,3,0), H, H, 8'h01, 0, 0, 8'd6);
    vecs[11] = mk(ri(8,1,8'hFF), ri(8,2,8'h01), rr(1,3,1,2), ri(8,3,8'h07), rr(12,0,3,0), H, H, H, 8'h07, 1, 1, 8'd5);
    vecs[12] = mk(ri(13,0,8'h04), ri(8,1,8'h11), rr(12,0,1,0), H, ri(8,1,8'h22), rr(12,0,1,0), H, H, 8'h22, 0, 0, 8'd6);

    // Default program, switches at 0x0A from reset
    bus.sw = 8'h0A;
    do_reset();
    chk("rst_pc", 32'(dut.pc), 0);
    chk("rst_led", 32'(bus.led), 0);
    chk("rst_z", 32'(dut.zf), 0);
    chk("rst_c", 32'(dut.cf), 0);
    chk("rst_halted", 32'(dut.halted), 0);
    chk("rst_sync", 32'(dut.sw_sync), 0);
    for (int k = 0; k < 7; k++) begin
      tick(1);
      chk($sformatf("dflt_pc%0d", k), 32'(dut.pc), 32'(dpc[k]));
      chk($sformatf("dflt_led%0d", k), 32'(bus.led), 32'(dled[k]));
    end

    // Switch change just after OUT: IN at the next loop still sees the old value
    bus.sw = 8'hFF;
    seen = 1'b0;
    lat = 0;
    for (int i = 1; i <= 16 && !seen; i++) begin
      tick(1);
      if (bus.led == 8'hFE) begin
        seen = 1'b1;
        lat = i;
      end
    end
    chk("sw_led_FE_seen", 32'(seen), 1);
    chk("sw_latency", 32'(lat), 8);
    chk("sw_add_c", 32'(dut.cf), 1);
    chk("sw_add_z", 32'(dut.zf), 0);

    // Instruction vectors
    for (int v = 0; v < NV; v++) begin
      rst_n = 1'b0;
      fill_rom(H);
      for (int i = 0; i < 8; i++) dut.rom[i] = vecs[v].prog[i];
      do_reset();
      tick(12);
      chk($sformatf("v%0d_led", v), 32'(bus.led), 32'(vecs[v].led));
      chk($sformatf("v%0d_z", v), 32'(dut.zf), 32'(vecs[v].z));
      chk($sformatf("v%0d_c", v), 32'(dut.cf), 32'(vecs[v].c));
      chk($sformatf("v%0d_pc", v), 32'(dut.pc), 32'(vecs[v].pc));
      chk($sformatf("v%0d_halted", v), 32'(dut.halted), 1);
    end

    // HALT at 0x10, then reset mid-run
    rst_n = 1'b0;
    fill_rom(16'h0000);
    dut.rom[0]     = ri(8, 1, 8'h3C);
    dut.rom[1]     = rr(12, 0, 1, 0);
    dut.rom[8'h10] = H;
    dut.rom[8'h11] = rr(12, 0, 0, 0);
    do_reset();
    tick(20);
    chk("halt_pc", 32'(dut.pc), 32'h10);
    chk("halt_flag", 32'(dut.halted), 1);
    chk("halt_led", 32'(bus.led), 32'h3C);
    tick(5);
    chk("halt_pc_hold", 32'(dut.pc), 32'h10);
    chk("halt_led_hold", 32'(bus.led), 32'h3C);
    rst_n = 1'b0;
    tick(1);
    chk("halt_rst_pc", 32'(dut.pc), 0);
    chk("halt_rst_led", 32'(bus.led), 0);
    chk("halt_rst_flag", 32'(dut.halted), 0);
    rst_n = 1'b1;
    tick(1);
    chk("rerun_pc", 32'(dut.pc), 1);
    rst_n = 1'b0;
    tick(1);
    chk("rst_over_out_led", 32'(bus.led), 0);
    chk("rst_over_out_pc", 32'(dut.pc), 0);

    // NOP fill: pc wrap, flags left alone by NOP and LDI
    rst_n = 1'b0;
    fill_rom(16'h0000);
    dut.rom[0] = ri(8, 1, 8'hFF);
    dut.rom[1] = ri(8, 2, 8'h01);
    dut.rom[2] = rr(1, 3, 1, 2);
    do_reset();
    tick(3);
    chk("wrap_pc3", 32'(dut.pc), 3);
    chk("wrap_z_set", 32'(dut.zf), 1);
    chk("wrap_c_set", 32'(dut.cf), 1);
    tick(252);
    chk("wrap_pcFF", 32'(dut.pc), 32'hFF);
    tick(1);
    chk("wrap_pc00", 32'(dut.pc), 0);
    tick(2);
    chk("wrap_pc2", 32'(dut.pc), 2);
    chk("wrap_z_kept", 32'(dut.zf), 1);
    chk("wrap_c_kept", 32'(dut.cf), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
